// File: rtl/mi_executor_if.sv
// Micro-instruction bus between the micro-instruction ROM (master) and the executor (slave).
interface mi_executor_if;
  logic [32:0] micro_instruction;
  logic        mi_valid;
  logic        HOLD;

  modport master (output micro_instruction, output mi_valid, input HOLD);
  modport slave  (input micro_instruction, input mi_valid, output HOLD);
endinterface

// File: rtl/mi_executor.sv
// Micro-instruction executor: latches one word, sequences memory and writeback, then releases HOLD.
// Optional trace outputs (retire_cnt, last_mi) are built when MI_TRACE_EN is defined.
module mi_executor #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         reset,
  mi_executor_if.slave mi_bus,
  input  logic         zero_flag,
  input  logic         carry_flag,
  input  logic         mem_ack,
  output logic [3:0]   alu_op,
  output logic [1:0]   sh_op,
  output logic         kmx_sel,
  output logic [4:0]   bus_a_sel,
  output logic [5:0]   bus_b_sel,
  output logic [5:0]   bus_c_sel,
  output logic         reg_we,
  output logic         w_we,
  output logic         z_we,
  output logic         cy_we,
  output logic         mem_req,
  output logic         mem_we,
  output logic         pc_load,
  output logic         pc_inc,
  output logic         mi_err
`ifdef MI_TRACE_EN
  ,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [32:0]      last_mi
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
    MEM_WAIT = 3'd2,
    WB       = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_r;
  logic [32:0]      mi_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             hold_r;
  logic             reg_we_r, w_we_r, z_we_r, cy_we_r;
  logic             mem_req_r, mem_we_r, pc_load_r, pc_inc_r, mi_err_r;
  logic [6:0]       t_word_s;
  logic             mr_s, mw_s, br_taken_s, enter_wb_s, strobe_en_s;
  logic             unused_s;
`ifdef MI_TRACE_EN
  logic [CNT_W-1:0] retire_cnt_r;
  logic [32:0]      last_mi_r;
`endif

  // Decode the held word; flags are taken on the edge that enters WB so the pulse lands in WB.
  always_comb begin
    t_word_s    = mi_r[11:5];
    mr_s        = mi_r[25];
    mw_s        = mi_r[24];
    br_taken_s  = 1'b1;
    enter_wb_s  = 1'b0;
    strobe_en_s = 1'b0;
    if (t_word_s[4]) begin
      br_taken_s = carry_flag;
    end else if (t_word_s[0]) begin
      br_taken_s = zero_flag;
    end else begin
      br_taken_s = 1'b1;
    end
    if (state_r == EXEC) begin
      enter_wb_s = ~(mr_s | mw_s);
    end else if (state_r == MEM_WAIT) begin
      enter_wb_s = mem_ack;
    end else begin
      enter_wb_s = 1'b0;
    end
    strobe_en_s = enter_wb_s & ~t_word_s[6];
  end

  assign unused_s = t_word_s[2];

  // Sequencer with registered strobes, memory request and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      mi_r       <= 33'd0;
      wait_cnt_r <= {CNT_W{1'b0}};
      hold_r     <= 1'b0;
      reg_we_r   <= 1'b0;
      w_we_r     <= 1'b0;
      z_we_r     <= 1'b0;
      cy_we_r    <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      pc_load_r  <= 1'b0;
      pc_inc_r   <= 1'b0;
      mi_err_r   <= 1'b0;
    end else begin
      reg_we_r  <= strobe_en_s & t_word_s[3];
      w_we_r    <= strobe_en_s & t_word_s[1];
      z_we_r    <= strobe_en_s & t_word_s[4];
      cy_we_r   <= strobe_en_s & t_word_s[5];
      pc_load_r <= enter_wb_s & t_word_s[6] & br_taken_s;
      pc_inc_r  <= enter_wb_s & ~(t_word_s[6] & br_taken_s);
      case (state_r)
        IDLE: begin
          if (mi_bus.mi_valid) begin
            mi_r    <= mi_bus.micro_instruction;
            hold_r  <= 1'b1;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (mr_s & mw_s) begin
            mi_err_r <= 1'b1;
            state_r  <= DONE;
          end else if (mr_s | mw_s) begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= mw_s;
            wait_cnt_r <= {CNT_W{1'b0}};
            state_r    <= MEM_WAIT;
          end else begin
            state_r <= WB;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            wait_cnt_r <= {CNT_W{1'b0}};
            state_r    <= WB;
          end else if (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mi_err_r   <= 1'b1;
            wait_cnt_r <= {CNT_W{1'b0}};
            state_r    <= DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        WB: begin
          state_r <= DONE;
        end
        DONE: begin
          hold_r  <= 1'b0;
          mi_r    <= 33'd0;
          state_r <= IDLE;
        end
        default: begin
          hold_r  <= 1'b0;
          mi_r    <= 33'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef MI_TRACE_EN
  // Retired-word counter and copy of the most recently accepted word.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_r <= {CNT_W{1'b0}};
      last_mi_r    <= 33'd0;
    end else begin
      if (state_r == DONE) begin
        retire_cnt_r <= retire_cnt_r + CNT_W'(1);
      end else begin
        retire_cnt_r <= retire_cnt_r;
      end
      if ((state_r == IDLE) && mi_bus.mi_valid) begin
        last_mi_r <= mi_bus.micro_instruction;
      end else begin
        last_mi_r <= last_mi_r;
      end
    end
  end

  assign retire_cnt = retire_cnt_r;
  assign last_mi    = last_mi_r;
`endif

  assign mi_bus.HOLD = hold_r;
  assign alu_op      = mi_r[32:29];
  assign sh_op       = mi_r[28:27];
  assign kmx_sel     = mi_r[26];
  assign bus_b_sel   = mi_r[23:18];
  assign bus_c_sel   = mi_r[17:12];
  assign bus_a_sel   = mi_r[4:0];
  assign reg_we      = reg_we_r;
  assign w_we        = w_we_r;
  assign z_we        = z_we_r;
  assign cy_we       = cy_we_r;
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign pc_load     = pc_load_r;
  assign pc_inc      = pc_inc_r;
  assign mi_err      = mi_err_r;

endmodule

// File: tb/tb_mi_executor.sv
// Directed bench for mi_executor; trace checks are compiled in when MI_TRACE_EN is defined.
module tb_mi_executor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zero_flag = 1'b0, carry_flag = 1'b0, mem_ack = 1'b0;
  logic [3:0] alu_op;
  logic [1:0] sh_op;
  logic       kmx_sel;
  logic [4:0] bus_a_sel;
  logic [5:0] bus_b_sel, bus_c_sel;
  logic       reg_we, w_we, z_we, cy_we, mem_req, mem_we, pc_load, pc_inc, mi_err;
`ifdef MI_TRACE_EN
  logic [7:0]  retire_cnt;
  logic [32:0] last_mi;
`endif

  mi_executor_if mi ();

  mi_executor #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mi_bus(mi.slave),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ack(mem_ack),
    .alu_op(alu_op), .sh_op(sh_op), .kmx_sel(kmx_sel),
    .bus_a_sel(bus_a_sel), .bus_b_sel(bus_b_sel), .bus_c_sel(bus_c_sel),
    .reg_we(reg_we), .w_we(w_we), .z_we(z_we), .cy_we(cy_we),
    .mem_req(mem_req), .mem_we(mem_we), .pc_load(pc_load), .pc_inc(pc_inc),
    .mi_err(mi_err)
`ifdef MI_TRACE_EN
    , .retire_cnt(retire_cnt), .last_mi(last_mi)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int n_wwe, n_rwe, n_zwe, n_cwe, n_inc, n_load, pc_cyc, hold_cyc, mreq_cyc, mwe_or, field_bad, cyc;
  int total_inc, total_cy;
  logic [32:0] last_w;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] mk_word(input logic [3:0] alu, input logic kmx, input logic mr,
                                          input logic mw, input logic [5:0] c, input logic [6:0] t,
                                          input logic [4:0] a);
    return {alu, 2'b01, kmx, mr, mw, 6'b001011, c, t, a};
  endfunction

  // ack_at: wait cycle (0-based) on which to ack; -1 never; -2 ack held high throughout.
  task automatic run_mi(input logic [32:0] w, input int ack_at, input bit spam);
    n_wwe = 0; n_rwe = 0; n_zwe = 0; n_cwe = 0; n_inc = 0; n_load = 0;
    pc_cyc = -1; hold_cyc = 0; mreq_cyc = 0; mwe_or = 0; field_bad = 0;
    mi.micro_instruction = w;
    mi.mi_valid = 1'b1;
    mem_ack = (ack_at == -2);
    tick;
    cyc = 1;
    if (spam) mi.micro_instruction = ~w;
    else mi.mi_valid = 1'b0;
    while (mi.HOLD && cyc < 64) begin
      hold_cyc++;
      if (alu_op !== w[32:29] || sh_op !== w[28:27] || kmx_sel !== w[26] ||
          bus_b_sel !== w[23:18] || bus_c_sel !== w[17:12] || bus_a_sel !== w[4:0]) field_bad++;
      n_wwe += int'(w_we); n_rwe += int'(reg_we); n_zwe += int'(z_we); n_cwe += int'(cy_we);
      n_inc += int'(pc_inc); n_load += int'(pc_load);
      if ((pc_inc || pc_load) && pc_cyc < 0) pc_cyc = cyc;
      if (mem_req) begin
        mwe_or |= int'(mem_we);
        mem_ack = (mreq_cyc == ack_at) || (ack_at == -2);
        mreq_cyc++;
      end else begin
        mem_ack = (ack_at == -2);
      end
      tick;
      cyc++;
    end
    mi.mi_valid = 1'b0;
    mem_ack = 1'b0;
    check_val("hold_release", {63'd0, mi.HOLD}, 64'd0);
  endtask

  initial begin
    mi.micro_instruction = 33'd0;
    mi.mi_valid = 1'b0;
    tick; tick;
    check_val("rst_hold", {63'd0, mi.HOLD}, 64'd0);
    check_val("rst_outs", {alu_op, bus_c_sel, mem_req, mi_err, pc_inc, pc_load, w_we}, 64'd0);
    reset = 1'b0;
    tick;

    // MOV W,#K
    run_mi(mk_word(4'd0, 1'b1, 1'b0, 1'b0, 6'b100010, 7'b0000010, 5'd0), -1, 1'b0);
    check_val("mov_hold", hold_cyc, 3);
    check_val("mov_pulses", {n_wwe, n_inc}, {32'd1, 32'd1});
    check_val("mov_quiet", {n_rwe, n_zwe, n_cwe, n_load}, 128'd0);
    check_val("mov_pc_cyc", pc_cyc, 2);
    check_val("mov_fields", field_bad, 0);
    check_val("idle_fields", {alu_op, kmx_sel, bus_c_sel}, 64'd0);

    // Same word with mi_valid spammed and a stray ack: neither may disturb it
    run_mi(mk_word(4'd5, 1'b1, 1'b0, 1'b0, 6'b100010, 7'b0000010, 5'd3), -2, 1'b1);
    check_val("spam_pulses", {n_wwe, n_inc, hold_cyc}, {32'd1, 32'd1, 32'd3});
    check_val("spam_fields", field_bad, 0);

    // MOM W,Y with ack on the fourth wait cycle
    run_mi(mk_word(4'd1, 1'b0, 1'b1, 1'b0, 6'b000001, 7'b0000010, 5'd7), 3, 1'b0);
    check_val("mom_rd_req", {mreq_cyc, mwe_or}, {32'd4, 32'd0});
    check_val("mom_rd_pulse", {n_wwe, n_inc, pc_cyc}, {32'd1, 32'd1, 32'd6});
    check_val("mom_rd_hold", hold_cyc, 7);

    // Ack coincident with mem_req rising
    run_mi(mk_word(4'd1, 1'b0, 1'b1, 1'b0, 6'b000001, 7'b0001000, 5'd7), 0, 1'b0);
    check_val("mom_ack0", {mreq_cyc, n_rwe, pc_cyc}, {32'd1, 32'd1, 32'd3});

    // Conditional and unconditional jumps
    zero_flag = 1'b1;
    run_mi(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 7'b1000001, 5'd0), -1, 1'b0);
    check_val("jze_taken", {n_load, n_inc, pc_cyc}, {32'd1, 32'd0, 32'd2});
    check_val("jze_nostrobe", {n_rwe, n_wwe, n_zwe, n_cwe}, 128'd0);
    zero_flag = 1'b0;
    run_mi(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 7'b1000001, 5'd0), -1, 1'b0);
    check_val("jze_not", {n_load, n_inc}, {32'd0, 32'd1});
    carry_flag = 1'b1;
    run_mi(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 7'b1010000, 5'd0), -1, 1'b0);
    check_val("jcy_taken", {n_load, n_inc}, {32'd1, 32'd0});
    carry_flag = 1'b0;
    zero_flag = 1'b1;
    run_mi(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 7'b1010000, 5'd0), -1, 1'b0);
    check_val("jcy_not", {n_load, n_inc}, {32'd0, 32'd1});
    zero_flag = 1'b0;
    run_mi(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 7'b1000000, 5'd0), -1, 1'b0);
    check_val("jmp_uncond", {n_load, n_inc}, {32'd1, 32'd0});
    check_val("err_clean", {63'd0, mi_err}, 64'd0);

    // MOM Y,W with no ack: timeout
    run_mi(mk_word(4'd2, 1'b0, 1'b0, 1'b1, 6'b000011, 7'b0001000, 5'd1), -1, 1'b0);
    check_val("to_req", {mreq_cyc, mwe_or}, {32'd16, 32'd1});
    check_val("to_nostrobe", {n_rwe, n_inc, n_load}, 96'd0);
    check_val("to_hold", hold_cyc, 18);
    check_val("to_err", {63'd0, mi_err}, 64'd1);
    run_mi(mk_word(4'd0, 1'b1, 1'b0, 1'b0, 6'b100010, 7'b0000010, 5'd0), -1, 1'b0);
    check_val("after_to", {n_wwe, n_inc}, {32'd1, 32'd1});
    check_val("err_sticky", {63'd0, mi_err}, 64'd1);

    // Reset in the middle of MEM_WAIT
    mi.micro_instruction = mk_word(4'd3, 1'b0, 1'b1, 1'b0, 6'd2, 7'b0000010, 5'd2);
    mi.mi_valid = 1'b1;
    tick;
    mi.mi_valid = 1'b0;
    tick; tick;
    check_val("pre_rst_req", {63'd0, mem_req}, 64'd1);
    reset = 1'b1;
    tick;
    check_val("mid_rst", {mem_req, mi.HOLD, mi_err, w_we, pc_inc, pc_load, alu_op}, 64'd0);
    reset = 1'b0;
    tick;

    // MR and MW both set
    run_mi(mk_word(4'd4, 1'b0, 1'b1, 1'b1, 6'd2, 7'b0001010, 5'd2), -2, 1'b0);
    check_val("mrmw_req", mreq_cyc, 0);
    check_val("mrmw_quiet", {n_rwe, n_wwe, n_inc, n_load}, 128'd0);
    check_val("mrmw_err", {63'd0, mi_err}, 64'd1);
    check_val("mrmw_hold", hold_cyc, 2);

    // 257 back-to-back ADW words from a clean reset
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total_inc = 0;
    total_cy = 0;
    last_w = 33'd0;
    for (int i = 0; i < 257; i++) begin
      last_w = mk_word(4'd6, 1'b0, 1'b0, 1'b0, 6'd5, 7'b0111101, 5'(i));
      run_mi(last_w, -1, 1'b0);
      total_inc += n_inc;
      total_cy += n_cwe + n_zwe + n_rwe - 2 * n_wwe;
    end
    check_val("adw_inc", total_inc, 257);
    check_val("adw_strobes", total_cy, 771);
`ifdef MI_TRACE_EN
    check_val("retire_wrap", {56'd0, retire_cnt}, 64'd1);
    check_val("last_mi", {31'd0, last_mi}, {31'd0, last_w});
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
